// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end for the RV32I core. Owns the architectural
// fetch PC, issues single-outstanding word requests to instruction memory and
// buffers returned words (with their PCs) in a 2-entry queue for the decoder.
// A redirect from the control unit flushes the queue and discards any
// response still in flight for the wrong path.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   pc_j_valid   in   redirect strobe (one cycle)
//   next_pc      in   redirect target, sampled with pc_j_valid
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch word address
//   imem_gnt     in   request accepted this cycle (when imem_req=1)
//   imem_rvalid  in   read data valid, one per granted request
//   imem_rdata   in   instruction word
//   instr_valid  out  queue head valid
//   instr        out  queue head instruction
//   pc           out  PC of the queue head
//   instr_ready  in   decoder accepts the head
//   misaligned   out  one-cycle pulse: redirect target had bits [1:0] != 0
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_j_valid,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        instr_ready,
    output logic        misaligned
);

    logic [31:0] r_fetch_pc;
    logic        r_outstanding;
    logic        r_drop;
    logic [31:0] r_tag;
    logic [31:0] r_q_pc    [0:1];
    logic [31:0] r_q_instr [0:1];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_misaligned;
    // Holds the request low until the first clock edge after reset release,
    // and drops it immediately when reset is asserted.
    logic        r_run;

    logic w_grant;
    logic w_resp;
    logic w_push;
    logic w_pop;

    assign imem_req    = r_run && !r_outstanding && (r_count < 2'd2) && !pc_j_valid;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != 2'd0);
    assign instr       = r_q_instr[r_rd_ptr];
    assign pc          = r_q_pc[r_rd_ptr];
    assign misaligned  = r_misaligned;

    assign w_grant = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp  = imem_rvalid && r_outstanding;
    assign w_push  = w_resp && !r_drop;
    assign w_pop   = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_tag         <= 32'h0;
            r_q_pc[0]     <= 32'h0;
            r_q_pc[1]     <= 32'h0;
            r_q_instr[0]  <= 32'h0;
            r_q_instr[1]  <= 32'h0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_misaligned  <= 1'b0;
            r_run         <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_misaligned <= pc_j_valid && (next_pc[1:0] != 2'b00);
            if (pc_j_valid) begin
                // Redirect wins over grant/push/pop in the same cycle.
                r_fetch_pc <= {next_pc[31:2], 2'b00};
                r_count    <= 2'd0;
                r_rd_ptr   <= 1'b0;
                r_wr_ptr   <= 1'b0;
                if (w_resp) begin
                    // The wrong-path word arrives right now: swallow it here.
                    r_outstanding <= 1'b0;
                    r_drop        <= 1'b0;
                end else if (r_outstanding) begin
                    r_drop <= 1'b1;
                end
            end else begin
                // Grant and response are mutually exclusive: a grant needs
                // nothing outstanding, a response needs something outstanding.
                if (w_grant) begin
                    r_outstanding <= 1'b1;
                    r_tag         <= r_fetch_pc;
                    r_fetch_pc    <= r_fetch_pc + 32'd4;
                end
                if (w_resp) begin
                    r_outstanding <= 1'b0;
                    r_drop        <= 1'b0;
                end
                if (w_push) begin
                    r_q_pc[r_wr_ptr]    <= r_tag;
                    r_q_instr[r_wr_ptr] <= imem_rdata;
                    r_wr_ptr            <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A memory responder with configurable
// grant probability and latency feeds the DUT; a reference model tracks the
// next expected request address, the next expected delivered PC and the
// number of live queued words, and checks the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        pc_j_valid;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_ready;
    logic        misaligned;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_j_valid  (pc_j_valid),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .instr_ready (instr_ready),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory responder configuration and state
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        mem_pend;
    int          mem_wait;
    logic [31:0] mem_addr;

    // reference model
    logic [31:0] m_req_next;
    logic [31:0] m_del_next;
    int          m_qcount;
    logic        m_live;
    logic        m_mis_exp;
    logic        m_started;

    logic [31:0] glog[$];
    logic [31:0] dlog[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hA5C3_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic apply_reset();
        reset       = 1'b1;
        pc_j_valid  = 1'b0;
        next_pc     = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        mem_pend   = 1'b0;
        mem_wait   = 0;
        mem_addr   = 32'h0;
        m_req_next = RST_PC;
        m_del_next = RST_PC;
        m_qcount   = 0;
        m_live     = 1'b0;
        m_mis_exp  = 1'b0;
        m_started  = 1'b0;
        glog.delete();
        dlog.delete();
        reset = 1'b0;
    endtask

    // One clock cycle: memory drives its outputs, the DUT is checked against
    // the model, then the model advances by what happens at the edge.
    task automatic step();
        logic pend_now, rv, exp_req, grant, pop;
        pend_now = mem_pend;
        rv = 1'b0;
        if (mem_pend) begin
            mem_wait = mem_wait - 1;
            if (mem_wait <= 0) rv = 1'b1;
        end
        imem_rvalid = rv;
        imem_rdata  = rv ? memfn(mem_addr) : $urandom;
        #1;
        imem_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
        #1;
        exp_req = m_started && !pend_now && (m_qcount < 2) && !pc_j_valid;
        checks++;
        if (imem_req !== exp_req) begin
            errors++;
            $display("FAIL imem_req: got %b want %b at %0t", imem_req, exp_req, $time);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr !== m_req_next) begin
                errors++;
                $display("FAIL imem_addr: got %h want %h at %0t", imem_addr, m_req_next, $time);
            end
        end
        checks++;
        if (misaligned !== m_mis_exp) begin
            errors++;
            $display("FAIL misaligned: got %b want %b at %0t", misaligned, m_mis_exp, $time);
        end
        checks++;
        if (instr_valid !== (m_qcount != 0)) begin
            errors++;
            $display("FAIL instr_valid: got %b want %b at %0t", instr_valid, (m_qcount != 0), $time);
        end
        if (m_qcount != 0) begin
            checks++;
            if (pc !== m_del_next || instr !== memfn(m_del_next)) begin
                errors++;
                $display("FAIL head: got pc %h instr %h want pc %h instr %h at %0t",
                         pc, instr, m_del_next, memfn(m_del_next), $time);
            end
        end
        grant = imem_req && imem_gnt;
        pop   = (m_qcount != 0) && instr_ready;
        if (rv) mem_pend = 1'b0;
        if (grant) begin
            mem_pend = 1'b1;
            mem_wait = int'($urandom_range(lat_max, lat_min));
            mem_addr = imem_addr;
            glog.push_back(imem_addr);
        end
        if (pc_j_valid) begin
            m_req_next = {next_pc[31:2], 2'b00};
            m_del_next = {next_pc[31:2], 2'b00};
            m_qcount   = 0;
            m_live     = 1'b0;
        end else begin
            if (rv && m_live) begin
                m_qcount++;
                m_live = 1'b0;
            end
            if (grant) begin
                m_req_next += 32'd4;
                m_live = 1'b1;
            end
            if (pop) begin
                dlog.push_back(m_del_next);
                m_del_next += 32'd4;
                m_qcount--;
            end
        end
        m_mis_exp = pc_j_valid && (next_pc[1:0] != 2'b00);
        @(posedge clk);
        m_started = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        instr_ready = 1'b1;
        apply_reset();
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req %b valid %b mis %b want 0 0 0", imem_req, instr_valid, misaligned);
        end
        checks++;
        if (pc !== 32'h0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_head: got pc %h instr %h want 0 0", pc, instr);
        end
        step();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: got req %b addr %h want 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_boot();
        instr_ready = 1'b1;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        repeat (14) step();
        checks++;
        if (glog.size() < 3 || dlog.size() < 3) begin
            errors++;
            $display("FAIL boot_count: got grants %0d delivered %0d want >=3", glog.size(), dlog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (glog[i] !== RST_PC + 32'(4 * i) || dlog[i] !== RST_PC + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL boot_seq%0d: got addr %h pc %h want %h", i, glog[i], dlog[i], RST_PC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        repeat (10) step();
        checks++;
        if (glog.size() != 2 || imem_req !== 1'b0 || instr_valid !== 1'b1 || pc !== RST_PC) begin
            errors++;
            $display("FAIL bp_full: got grants %0d req %b valid %b pc %h want 2 0 1 %h",
                     glog.size(), imem_req, instr_valid, pc, RST_PC);
        end
        instr_ready = 1'b1;
        repeat (6) step();
        checks++;
        if (dlog.size() < 2 || dlog[0] !== RST_PC || dlog[1] !== RST_PC + 32'd4) begin
            errors++;
            $display("FAIL bp_drain: got %0d entries want %h then %h", dlog.size(), RST_PC, RST_PC + 32'd4);
        end
    endtask

    task automatic test_redirect_outstanding();
        int n;
        bit found;
        instr_ready = 1'b1;
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        apply_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (glog.size() > 0 && glog[glog.size() - 1] == 32'h108 && mem_pend) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redir_wait: got no grant of %h want one within 40 cycles", 32'h108);
        end
        n = glog.size();
        dlog.delete();
        pc_j_valid = 1'b1; next_pc = 32'h400;
        step();
        pc_j_valid = 1'b0;
        repeat (14) step();
        checks++;
        if (glog.size() <= n || glog[n] !== 32'h400 || dlog.size() == 0 || dlog[0] !== 32'h400) begin
            errors++;
            $display("FAIL redir_target: got grants %0d delivered %0d want first %h", glog.size() - n, dlog.size(), 32'h400);
        end
        foreach (dlog[i]) begin
            checks++;
            if (dlog[i] == 32'h108) begin
                errors++;
                $display("FAIL redir_drop: got pc %h delivered want it discarded", dlog[i]);
            end
        end
    endtask

    task automatic test_coincident();
        int n;
        bit found;
        instr_ready = 1'b0;
        gnt_pct = 100; lat_min = 2; lat_max = 2;
        apply_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_qcount == 1 && mem_pend && mem_wait == 1) found = 1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL coinc_wait: got no setup state want one within 40 cycles");
        end
        n = glog.size();
        instr_ready = 1'b1;
        pc_j_valid = 1'b1; next_pc = 32'h300;
        step();
        pc_j_valid = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL coinc_after: got valid %b req %b addr %h want 0 1 %h", instr_valid, imem_req, imem_addr, 32'h300);
        end
        repeat (6) step();
        checks++;
        if (glog.size() <= n || glog[n] !== 32'h300) begin
            errors++;
            $display("FAIL coinc_req: got %0d new grants want first %h", glog.size() - n, 32'h300);
        end
    endtask

    task automatic test_misaligned();
        int n;
        instr_ready = 1'b1;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        repeat (4) step();
        n = glog.size();
        dlog.delete();
        pc_j_valid = 1'b1; next_pc = 32'h203;
        step();
        pc_j_valid = 1'b0;
        checks++;
        if (misaligned !== 1'b1) begin
            errors++;
            $display("FAIL mis_pulse: got %b want 1", misaligned);
        end
        step();
        checks++;
        if (misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_clear: got %b want 0", misaligned);
        end
        repeat (8) step();
        checks++;
        if (glog.size() <= n || glog[n] !== 32'h200 || dlog.size() == 0 || dlog[0] !== 32'h200) begin
            errors++;
            $display("FAIL mis_resume: got %0d grants %0d delivered want first %h", glog.size() - n, dlog.size(), 32'h200);
        end
    endtask

    task automatic test_wrap_reset();
        int n;
        bit found;
        instr_ready = 1'b1;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        repeat (3) step();
        n = glog.size();
        dlog.delete();
        pc_j_valid = 1'b1; next_pc = 32'hFFFF_FFFC;
        step();
        pc_j_valid = 1'b0;
        repeat (8) step();
        checks++;
        if (glog.size() < n + 2 || glog[n] !== 32'hFFFF_FFFC || glog[n + 1] !== 32'h0 ||
            dlog.size() < 2 || dlog[0] !== 32'hFFFF_FFFC || dlog[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap: got %0d grants %0d delivered want %h then %h", glog.size() - n, dlog.size(), 32'hFFFF_FFFC, 32'h0);
        end
        instr_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_qcount == 1 && !mem_pend) found = 1;
            else step();
        end
        checks++;
        if (!found || imem_req !== 1'b1 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL prereset: got found %b req %b valid %b want 1 1 1", found, imem_req, instr_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid %b req %b want 0 0", instr_valid, imem_req);
        end
        apply_reset();
    endtask

    task automatic test_random();
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(3, 0) != 0);
            pc_j_valid  = ($urandom_range(19, 0) == 0);
            next_pc     = $urandom;
            if ($urandom_range(3, 0) != 0) next_pc[1:0] = 2'b00;
            step();
        end
        pc_j_valid = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        reset       = 1'b1;
        pc_j_valid  = 1'b0;
        next_pc     = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        test_reset();
        test_boot();
        test_backpressure();
        test_redirect_outstanding();
        test_coincident();
        test_misaligned();
        test_wrap_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RV32I core. Owns the architectural fetch PC. Issues word requests to instruction memory with at most one request outstanding, and buffers returned words with their PCs in a 2-entry queue for the decoder. It consumes the branch/jump redirect (`pc_j_valid`, `next_pc`) produced by the control unit. On a redirect it flushes everything fetched down the wrong path.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `pc_j_valid`  in  1: redirect strobe from the control unit, one cycle.
- `next_pc`  in  32: redirect target, sampled when `pc_j_valid`=1.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch word address.
- `imem_gnt`  in  1: request accepted this cycle when `imem_req`=1.
- `imem_rvalid`  in  1: read data valid; exactly one per granted request, at least 1 cycle after the grant.
- `imem_rdata`  in  32: instruction word.
- `instr_valid`  out  1: queue head valid.
- `instr`  out  32: queue head instruction.
- `pc`  out  32: PC of the queue head.
- `instr_ready`  in  1: decoder accepts the head.
- `misaligned`  out  1: one-cycle pulse, redirect target had bits [1:0] != 0.

## Operation
- State registers:
  - `fetch_pc` (32)
  - `outstanding` (1)
  - `drop` (1), which marks the outstanding response to be discarded
  - 2-entry queue of {pc, instr}, with read pointer, write pointer and `count` (0..2)
- Request condition: `imem_req` = !`outstanding` && (`count` < 2) && !`pc_j_valid`.
- `imem_addr` = `fetch_pc`.
- Request hold rule: while `imem_req`=1 and `imem_gnt`=0, `imem_addr` stays stable. Only a redirect may withdraw the request.
- Grant (`imem_req` && `imem_gnt`):
  - `outstanding` <= 1
  - queue tag <= `fetch_pc`
  - `fetch_pc` <= `fetch_pc` + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Response (`imem_rvalid`):
  - `outstanding` <= 0.
  - If `drop`=0, push {tag, `imem_rdata`} into the queue.
  - If `drop`=1, discard the word and clear `drop`.
  - `imem_rvalid` while `outstanding`=0 is a protocol error and is ignored.
- Pop: `instr_valid` && `instr_ready` advances the read pointer.
  - `instr_valid` = (`count` != 0).
  - `instr` and `pc` are the head entry.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Redirect (`pc_j_valid`=1) takes priority over all other events that cycle:
  - `fetch_pc` <= {`next_pc`[31:2], 2'b00}; `misaligned` <= (`next_pc`[1:0] != 0).
  - Queue flushed: `count` <= 0, pointers <= 0. Any pop or push in this cycle is discarded.
  - If `outstanding`=1 and no `imem_rvalid` arrives this cycle, set `drop` <= 1.
  - If `imem_rvalid` arrives this cycle, the word is discarded and `outstanding` <= 0.
  - `imem_req`=0 this cycle, so no grant can occur.
- Redirect while `drop` is already 1: `drop` stays 1, and the new target overwrites `fetch_pc`.

## Timing
- Reset values (asynchronous):
  - `fetch_pc`=`RESET_PC`
  - `outstanding`=0, `drop`=0, `count`=0, so `instr_valid`=0 and `imem_req` low until the first edge after release
  - `misaligned`=0
  - queue `instr` and `pc` read as 0
- First cycle after reset deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Reset asserted mid-transaction returns every register to its reset value immediately. A pending memory response after reset is the memory's responsibility (it must also be reset).
- Fetch latency: grant at cycle G, `imem_rvalid` at G+k (k≥1), so `instr_valid`=1 at G+k+1.
- Redirect at T with nothing outstanding: `imem_req`=1 with `imem_addr`=target at T+1.
- Redirect at T with a response outstanding: the next request starts the cycle after the dropped `imem_rvalid`.
- Throughput: one instruction per (memory latency + 1) cycles, because at most one request is outstanding.
- Full queue (`count`=2): no request is issued; requests resume the cycle after a pop.

## Test plan
- **Reset boot:** `RESET_PC`=0x100, memory with fixed 1-cycle latency, `instr_ready`=1 → `imem_addr` sequence 0x100, 0x104, 0x108; `pc`/`instr` pairs delivered in order with matching data.
- **Backpressure:** `instr_ready`=0 for 10 cycles → exactly 2 entries accepted and `imem_req`=0 while full. Releasing ready drains 0x100 then 0x104 with no loss or duplication.
- **Redirect with outstanding response:** grant 0x108, then `pc_j_valid`=1 with `next_pc`=0x400 before its rvalid → 0x108 word never appears; queue empties; next request is 0x400, and 0x400 is the first `pc` delivered.
- **Redirect coincident with rvalid and pop:** same cycle → `instr_valid`=0 next cycle; the next request is the target address.
- **Misaligned target:** `next_pc`=0x203 → `misaligned` pulses 1 cycle; fetch resumes at 0x200.
- **Wrap-around and async reset:** redirect to 0xFFFF_FFFC → next fetch 0x0000_0000. Asserting `reset` mid-fetch → `instr_valid` and `imem_req` drop without waiting for a clock edge.
